// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// The scanner FSM encoding is exported so a bench can observe it directly.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Index of the lowest-numbered active-low row; rows are assumed not all high.
    function automatic logic [1:0] first_low(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer with a configurable idle value loaded on reset.
module sync_2ff #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, press/release debounce on the
// 1 kHz scan tick, and a valid/ready output with a sticky overrun flag.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                slow_clk,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [3:0]          key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                overrun,
    output state_t              fsm_state
);

    localparam int CNT_W = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                slow_s;
    logic                slow_d;
    logic                tick;
    logic [NUM_ROWS-1:0] rows_s;

    state_t           state, next_state;
    logic [CNT_W-1:0] count, next_count, count_inc;
    logic [1:0]       col_idx, next_col_idx;
    logic [1:0]       row_idx, next_row_idx;
    logic             emit;
    logic [3:0]       emit_code;
    logic             all_high;
    logic             xfer;

    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_slow (
        .clk (clk),
        .rst (rst),
        .d   (slow_clk),
        .q   (slow_s)
    );

    sync_2ff #(.WIDTH(NUM_ROWS), .RESET_VAL({NUM_ROWS{1'b1}})) u_sync_rows (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (rows_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) slow_d <= 1'b0;
        else     slow_d <= slow_s;
    end

    assign tick      = slow_s && !slow_d;
    assign all_high  = &rows_s;
    assign count_inc = count + CNT_ONE;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SCAN;
            count   <= '0;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
        end else begin
            state   <= next_state;
            count   <= next_count;
            col_idx <= next_col_idx;
            row_idx <= next_row_idx;
        end
    end

    // Next-state logic; everything holds outside tick cycles.
    always_comb begin
        next_state   = state;
        next_count   = count;
        next_col_idx = col_idx;
        next_row_idx = row_idx;
        emit         = 1'b0;
        emit_code    = {row_idx, col_idx};
        if (tick) begin
            case (state)
                SCAN: begin
                    if (!all_high) begin
                        next_row_idx = first_low(rows_s);
                        next_count   = CNT_ONE;
                        next_state   = DEBOUNCE;
                        if (DEBOUNCE_TICKS <= 1) begin
                            emit       = 1'b1;
                            emit_code  = {first_low(rows_s), col_idx};
                            next_count = '0;
                            next_state = HELD;
                        end
                    end else begin
                        next_col_idx = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!rows_s[row_idx]) begin
                        next_count = count_inc;
                        if (count_inc == CNT_MAX) begin
                            emit       = 1'b1;
                            next_count = '0;
                            next_state = HELD;
                        end
                    end else begin
                        next_count = '0;
                        next_state = SCAN;
                    end
                end
                HELD: begin
                    if (all_high) begin
                        next_count = CNT_ONE;
                        next_state = RELEASE;
                        if (DEBOUNCE_TICKS <= 1) begin
                            next_count = '0;
                            next_state = SCAN;
                        end
                    end
                end
                RELEASE: begin
                    if (all_high) begin
                        next_count = count_inc;
                        if (count_inc == CNT_MAX) begin
                            next_count = '0;
                            next_state = SCAN;
                        end
                    end else begin
                        next_count = '0;
                        next_state = HELD;
                    end
                end
                default: begin
                    next_count = '0;
                    next_state = SCAN;
                end
            endcase
        end
    end

    // Outputs derived from state
    always_comb begin
        col_out   = ~(4'b0001 << col_idx);
        fsm_state = state;
    end

    // Handshake: key_valid/key_code form a valid/ready pair; a transfer happens
    // on any clk edge with key_valid && key_ready, and key_code is stable while
    // key_valid is high. An emit that coincides with a transfer replaces the key.
    assign xfer = key_valid && key_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (emit) begin
            if (!key_valid || xfer) begin
                key_code  <= emit_code;
                key_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (xfer) begin
            key_valid <= 1'b0;
        end
    end

endmodule
